i2c_target: RTL and testbench

- 7-bit-addressed I2C target (slave) that answers the bus driven by the team's I2C master.
- Oversamples SCL/SDA on clk_in, detects START, repeated START and STOP, and matches the address.
- Write transfers: received bytes are handed to the user logic.
- Read transfers: the user logic is asked for bytes, which are shifted out to the master. SDA is open-drain only.

---
 rtl/i2c_target.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// 7-bit addressed I2C target: oversampled SCL/SDA, START/STOP detection, open-drain SDA.
// Optional `define I2C_TARGET_STRETCH_EN holds SCL low until the user supplies a read byte.
module i2c_target #(
    parameter logic [6:0]  ADDRESS        = 7'h50,
    parameter int unsigned INPUT_CLK_RATE = 50000000,
    parameter int unsigned HOLD_CYCLES    = 15
) (
    input  logic       clk_in,
    input  logic       reset_n,
    inout  wire        scl,
    inout  wire        sda,
    output logic       busy,
    output logic       addressed,
    output logic       mode,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       tx_request,
    input  logic [7:0] data_tx,
    input  logic       tx_valid,
    output logic       stop_seen
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    // Bus timing is derived from HOLD_CYCLES; the clock rate is kept for documentation.
    localparam int unsigned UNUSED_CLK_RATE = INPUT_CLK_RATE;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_IGNORE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_prev_q, sda_prev_q;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        tx_q, tx_d;
    logic              tx_load_q, tx_load_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_act_q, pend_act_d;
    logic              pend_val_q, pend_val_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              addressed_q, addressed_d;
    logic              mode_q, mode_d;
    logic [7:0]        data_rx_q, data_rx_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_request_q, tx_request_d;
    logic              stop_seen_q, stop_seen_d;

    logic              scl_s, sda_s;
    logic              scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [7:0]        rx_byte_c;
    logic              first_tx_bit_c;
    logic              fall_drive_c;

    assign scl_s          = scl_sync_q[1];
    assign sda_s          = sda_sync_q[1];
    assign scl_rise_c     = scl_s & ~scl_prev_q;
    assign scl_fall_c     = ~scl_s & scl_prev_q;
    assign start_c        = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c         = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte_c      = {shift_q, sda_s};
    assign first_tx_bit_c = (state_q == S_TX_BYTE) && (bit_cnt_q == 4'd0);

`ifdef I2C_TARGET_STRETCH_EN
    logic stretch_q, stretch_d;
    logic scl_oe_q, scl_oe_d;
    logic scl_rel_q, scl_rel_d;
    assign scl = scl_oe_q ? 1'b0 : 1'bz;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
`endif

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign addressed  = addressed_q;
    assign mode       = mode_q;
    assign data_rx    = data_rx_q;
    assign rx_valid   = rx_valid_q;
    assign tx_request = tx_request_q;
    assign stop_seen  = stop_seen_q;

    // SDA level wanted for the low phase that starts at this SCL fall (1 = pull low)
    always_comb begin
        fall_drive_c = 1'b0;
        case (state_q)
            S_ADDR_ACK, S_RX_ACK: fall_drive_c = (bit_cnt_q == 4'd8);
            S_TX_BYTE:            fall_drive_c = (bit_cnt_q < 4'd8) ? ~tx_q[3'(4'd7 - bit_cnt_q)] : 1'b0;
            default:              fall_drive_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = S_ADDR;
        end else if (stop_c) begin
            state_d = S_IDLE;
        end else if (scl_rise_c) begin
            case (state_q)
                S_ADDR:     if (bit_cnt_q == 4'd7) state_d = (shift_q == ADDRESS) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (bit_cnt_q == 4'd8) state_d = mode_q ? S_TX_BYTE : S_RX_BYTE;
                S_RX_BYTE:  if (bit_cnt_q == 4'd7) state_d = S_RX_ACK;
                S_RX_ACK:   if (bit_cnt_q == 4'd8) state_d = S_RX_BYTE;
                S_TX_BYTE:  if (bit_cnt_q == 4'd7) state_d = S_TX_ACK;
                S_TX_ACK:   if (bit_cnt_q == 4'd8) state_d = sda_s ? S_IGNORE : S_TX_BYTE;
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        tx_load_d    = tx_load_q;
        hold_cnt_d   = hold_cnt_q;
        pend_act_d   = pend_act_q;
        pend_val_d   = pend_val_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        addressed_d  = addressed_q;
        mode_d       = mode_q;
        data_rx_d    = data_rx_q;
        rx_valid_d   = 1'b0;
        tx_request_d = 1'b0;
        stop_seen_d  = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
        stretch_d    = stretch_q;
        scl_oe_d     = scl_oe_q;
        scl_rel_d    = 1'b0;

        // Read byte is taken only once the user marks it valid; a stretch ends here
        if (tx_load_q && tx_valid) begin
            tx_d      = data_tx;
            tx_load_d = 1'b0;
            if (stretch_q) begin
                sda_oe_d  = ~data_tx[7];
                stretch_d = 1'b0;
                scl_rel_d = 1'b1;
            end
        end
        if (scl_rel_q) scl_oe_d = 1'b0;
`else
        if (tx_load_q) begin
            tx_d      = data_tx;
            tx_load_d = 1'b0;
        end
`endif

        if (pend_act_q) begin
            if (hold_cnt_q <= HOLD_W'(1)) begin
                pend_act_d = 1'b0;
                sda_oe_d   = pend_val_q;
`ifdef I2C_TARGET_STRETCH_EN
                if (first_tx_bit_c && tx_load_q) begin
                    if (tx_valid) begin
                        sda_oe_d = ~data_tx[7];
                    end else begin
                        sda_oe_d  = 1'b0;
                        stretch_d = 1'b1;
                        scl_oe_d  = 1'b1;
                    end
                end
`endif
            end else begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
        end

        if (scl_fall_c) begin
            pend_act_d = 1'b1;
            hold_cnt_d = HOLD_W'(HOLD_CYCLES);
            pend_val_d = fall_drive_c;
        end

        if (scl_rise_c) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = (bit_cnt_q >= 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
            case (state_q)
                S_ADDR: if (bit_cnt_q == 4'd7) begin
                    addressed_d = (shift_q == ADDRESS);
                    if (shift_q == ADDRESS) mode_d = sda_s;
                end
                S_ADDR_ACK: if (bit_cnt_q == 4'd8 && mode_q) begin
                    tx_request_d = 1'b1;
                    tx_load_d    = 1'b1;
                end
                S_RX_BYTE: if (bit_cnt_q == 4'd7) begin
                    data_rx_d  = rx_byte_c;
                    rx_valid_d = 1'b1;
                end
                S_TX_ACK: if (bit_cnt_q == 4'd8 && !sda_s) begin
                    tx_request_d = 1'b1;
                    tx_load_d    = 1'b1;
                end
                default: ;
            endcase
        end

        // Bus conditions override any bit-level activity and cancel pending SDA changes
        if (start_c || stop_c) begin
            sda_oe_d   = 1'b0;
            pend_act_d = 1'b0;
            tx_load_d  = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            stretch_d  = 1'b0;
            scl_oe_d   = 1'b0;
`endif
            if (start_c) begin
                busy_d    = 1'b1;
                bit_cnt_d = 4'd0;
            end else begin
                busy_d      = 1'b0;
                stop_seen_d = addressed_q;
                addressed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= 7'd0;
            tx_q         <= 8'd0;
            tx_load_q    <= 1'b0;
            hold_cnt_q   <= HOLD_W'(0);
            pend_act_q   <= 1'b0;
            pend_val_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            addressed_q  <= 1'b0;
            mode_q       <= 1'b0;
            data_rx_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            tx_request_q <= 1'b0;
            stop_seen_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            tx_load_q    <= tx_load_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_act_q   <= pend_act_d;
            pend_val_q   <= pend_val_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            addressed_q  <= addressed_d;
            mode_q       <= mode_d;
            data_rx_q    <= data_rx_d;
            rx_valid_q   <= rx_valid_d;
            tx_request_q <= tx_request_d;
            stop_seen_q  <= stop_seen_d;
        end
    end

`ifdef I2C_TARGET_STRETCH_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            stretch_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            scl_rel_q <= 1'b0;
        end else begin
            stretch_q <= stretch_d;
            scl_oe_q  <= scl_oe_d;
            scl_rel_q <= scl_rel_d;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus master tasks, scoreboards for received and read bytes.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int Q = 100;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       m_scl_low, m_sda_low;
    logic [7:0] data_tx;
    logic       tx_valid;
    wire        scl_bus, sda_bus;
    wire        busy, addressed, mode, rx_valid, tx_request, stop_seen;
    wire [7:0]  data_rx;

    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    i2c_target dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .scl        (scl_bus),
        .sda        (sda_bus),
        .busy       (busy),
        .addressed  (addressed),
        .mode       (mode),
        .data_rx    (data_rx),
        .rx_valid   (rx_valid),
        .tx_request (tx_request),
        .data_tx    (data_tx),
        .tx_valid   (tx_valid),
        .stop_seen  (stop_seen)
    );

    always #5 clk_in = ~clk_in;

    int         checks = 0;
    int         failures = 0;
    int         rx_cnt = 0, txreq_cnt = 0, stop_cnt = 0, dut_sda_cnt = 0, stretch_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] rd_exp[$];
    logic [7:0] rx_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: received bytes are scored against the write scoreboard
    always @(negedge clk_in) begin
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            check("rx_expected_pending", 32'(rx_exp.size() != 0), 32'd1);
            if (rx_exp.size() != 0) begin
                rx_e = rx_exp.pop_front();
                check("rx_data", 32'(data_rx), 32'(rx_e));
            end
        end
        if (tx_request === 1'b1) txreq_cnt++;
        if (stop_seen === 1'b1) stop_cnt++;
        if (!m_sda_low && sda_bus === 1'b0) dut_sda_cnt++;
        if (!m_scl_low && scl_bus === 1'b0) stretch_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic scl_release();
        int t;
        t = 0;
        m_scl_low = 1'b0;
        while (scl_bus !== 1'b1 && t < 3000) begin
            @(posedge clk_in);
            t++;
        end
        check("scl_high", 32'(scl_bus), 32'd1);
    endtask

    task automatic m_start();
        m_sda_low = 1'b0; wait_clks(Q);
        scl_release();    wait_clks(Q);
        m_sda_low = 1'b1; wait_clks(Q);
        m_scl_low = 1'b1; wait_clks(Q);
    endtask

    task automatic m_stop();
        wait_clks(5);
        m_sda_low = 1'b1; wait_clks(Q);
        scl_release();    wait_clks(Q);
        m_sda_low = 1'b0; wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        wait_clks(5);
        m_sda_low = ~b;   wait_clks(Q);
        scl_release();    wait_clks(Q);
        m_scl_low = 1'b1;
    endtask

    task automatic read_bit(output logic b);
        wait_clks(5);
        m_sda_low = 1'b0; wait_clks(Q);
        scl_release();    wait_clks(Q / 2);
        b = sda_bus;      wait_clks(Q / 2);
        m_scl_low = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic bt;
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            read_bit(bt);
            b = {b[6:0], bt};
        end
        write_bit(nack);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         s0, r0, t0, d0, st0;

        reset_n = 1'b0; m_scl_low = 1'b0; m_sda_low = 1'b0;
        data_tx = 8'd0; tx_valid = 1'b1;
        wait_clks(5);
        check("reset_outputs", 32'({busy, addressed, mode, rx_valid, tx_request, stop_seen, data_rx}), 32'd0);
        check("reset_lines", 32'({scl_bus, sda_bus}), 32'd3);
        reset_n = 1'b1;
        wait_clks(20);

        // Write 0x50 W, 0xA5, 0x3C
        s0 = stop_cnt; r0 = rx_cnt;
        m_start();
        check("wr_busy", 32'(busy), 32'd1);
        rx_exp.push_back(8'hA5);
        rx_exp.push_back(8'h3C);
        write_byte({7'h50, 1'b0}, ack); check("wr_addr_ack", 32'(ack), 32'd0);
        check("wr_addressed", 32'({addressed, mode}), 32'b10);
        write_byte(8'hA5, ack); check("wr_b0_ack", 32'(ack), 32'd0);
        write_byte(8'h3C, ack); check("wr_b1_ack", 32'(ack), 32'd0);
        m_stop(); wait_clks(10);
        check("wr_idle", 32'({busy, addressed}), 32'd0);
        check("wr_stop_seen", 32'(stop_cnt - s0), 32'd1);
        check("wr_rx_count", 32'(rx_cnt - r0), 32'd2);

        // Wrong address 0x51 W
        s0 = stop_cnt; r0 = rx_cnt; d0 = dut_sda_cnt;
        m_start();
        write_byte({7'h51, 1'b0}, ack); check("na_ack", 32'(ack), 32'd1);
        check("na_addressed", 32'(addressed), 32'd0);
        write_byte(8'h99, ack); check("na_b0_ack", 32'(ack), 32'd1);
        m_stop(); wait_clks(10);
        check("na_sda_driven", 32'(dut_sda_cnt - d0), 32'd0);
        check("na_rx_count", 32'(rx_cnt - r0), 32'd0);
        check("na_stop_seen", 32'(stop_cnt - s0), 32'd0);

        // Read 0x50 R, two bytes, ACK then NACK
        s0 = stop_cnt; t0 = txreq_cnt;
        data_tx = 8'h81; rd_exp.push_back(8'h81);
        m_start();
        write_byte({7'h50, 1'b1}, ack); check("rd_addr_ack", 32'(ack), 32'd0);
        check("rd_mode", 32'({addressed, mode}), 32'b11);
        data_tx = 8'h7E; rd_exp.push_back(8'h7E);
        read_byte(rb, 1'b0); check("rd_byte0", 32'(rb), 32'(rd_exp.pop_front()));
        data_tx = 8'h00;
        read_byte(rb, 1'b1); check("rd_byte1", 32'(rb), 32'(rd_exp.pop_front()));
        wait_clks(Q);
        check("rd_sda_released", 32'(sda_bus), 32'd1);
        check("rd_txreq_count", 32'(txreq_cnt - t0), 32'd2);
        m_stop(); wait_clks(10);
        check("rd_stop_seen", 32'(stop_cnt - s0), 32'd1);

        // Write then repeated START into a read
        s0 = stop_cnt;
        m_start();
        rx_exp.push_back(8'h01);
        write_byte({7'h50, 1'b0}, ack); check("rs_wr_ack", 32'(ack), 32'd0);
        write_byte(8'h01, ack); check("rs_b0_ack", 32'(ack), 32'd0);
        check("rs_mode_before", 32'(mode), 32'd0);
        data_tx = 8'h3C; rd_exp.push_back(8'h3C);
        m_start();
        check("rs_busy_addressed", 32'({busy, addressed}), 32'b11);
        write_byte({7'h50, 1'b1}, ack); check("rs_rd_ack", 32'(ack), 32'd0);
        check("rs_state", 32'({busy, addressed, mode}), 32'b111);
        check("rs_no_stop", 32'(stop_cnt - s0), 32'd0);
        read_byte(rb, 1'b1); check("rs_byte", 32'(rb), 32'(rd_exp.pop_front()));
        m_stop(); wait_clks(10);

        // Reset mid-byte during a read while the target pulls SDA low (0x81 bit 5)
        data_tx = 8'h81;
        m_start();
        write_byte({7'h50, 1'b1}, ack); check("rst_addr_ack", 32'(ack), 32'd0);
        read_bit(ack); check("rst_bit7", 32'(ack), 32'd1);
        read_bit(ack); check("rst_bit6", 32'(ack), 32'd0);
        wait_clks(40);
        check("rst_sda_driven", 32'(sda_bus), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_sda_released", 32'(sda_bus), 32'd1);
        check("rst_outputs", 32'({busy, addressed, mode, rx_valid, tx_request, stop_seen, data_rx}), 32'd0);
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(10);
        m_stop();
        s0 = stop_cnt;
        m_start();
        rx_exp.push_back(8'h5A);
        write_byte({7'h50, 1'b0}, ack); check("post_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h5A, ack); check("post_b0_ack", 32'(ack), 32'd0);
        m_stop(); wait_clks(10);
        check("post_stop_seen", 32'(stop_cnt - s0), 32'd1);

`ifdef I2C_TARGET_STRETCH_EN
        // Read with tx_valid withheld: SCL must be stretched
        st0 = stretch_cnt;
        tx_valid = 1'b0; data_tx = 8'h81; rd_exp.push_back(8'h81);
        m_start();
        write_byte({7'h50, 1'b1}, ack); check("st_addr_ack", 32'(ack), 32'd0);
        fork
            begin wait_clks(600); tx_valid = 1'b1; end
            begin read_byte(rb, 1'b1); end
        join
        check("st_byte", 32'(rb), 32'(rd_exp.pop_front()));
        check("st_stretched", 32'((stretch_cnt - st0) >= 500), 32'd1);
        m_stop(); wait_clks(10);
`else
        st0 = stretch_cnt;
        check("no_stretch", 32'(st0), 32'd0);
`endif

        check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
